// File: rtl/control_sequencer_pkg.sv
// Shared types and encodings for the RV32I multicycle control sequencer.
// The HALTED state exists only when CONTROL_SEQUENCER_DEBUG_HALT_EN is defined.
package control_sequencer_pkg;

`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_TRAP   = 3'd5,
        ST_HALTED = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;
`endif

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_PC4 = 2'd2;
    localparam logic [1:0] RD_CSR = 2'd3;

    localparam logic [1:0] ALU1_RS1  = 2'd0;
    localparam logic [1:0] ALU1_PC   = 2'd1;
    localparam logic [1:0] ALU1_ZERO = 2'd2;

    localparam logic [1:0] ALU2_RS2  = 2'd0;
    localparam logic [1:0] ALU2_IMM  = 2'd1;
    localparam logic [1:0] ALU2_FOUR = 2'd2;

    localparam logic [3:0] CAUSE_IALIGN      = 4'd0;
    localparam logic [3:0] CAUSE_IFETCH      = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_ALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_ALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

endpackage

// File: rtl/control_sequencer_if.sv
// Decoder/checker/memory-status inputs and control strobes of the sequencer.
// master = sequencer side, slave = datapath/decoder/memory side.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       mem_complete_read;
    logic       mem_complete_write;
    logic       branch_taken;
    logic       fault_inst;
    logic       fault_ialign;
    logic       fault_mem;
    logic       fault_csr;

    logic       check_inst;
    logic       check_ialign;
    logic       check_mem;
    logic       check_csr;
    logic       write_pc;
    logic       write_ir;
    logic       write_rd;
    logic       write_csr;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu_insel1;
    logic [1:0] alu_insel2;
    logic       trap;
    logic [3:0] trap_cause;

    modport master (
        input  opcode, f3, mem_complete_read, mem_complete_write, branch_taken,
               fault_inst, fault_ialign, fault_mem, fault_csr,
        output check_inst, check_ialign, check_mem, check_csr,
               write_pc, write_ir, write_rd, write_csr,
               mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
               trap, trap_cause
    );

    modport slave (
        output opcode, f3, mem_complete_read, mem_complete_write, branch_taken,
               fault_inst, fault_ialign, fault_mem, fault_csr,
        input  check_inst, check_ialign, check_mem, check_csr,
               write_pc, write_ir, write_rd, write_csr,
               mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
               trap, trap_cause
    );

endinterface

// File: rtl/control_sequencer_mem_wait_timer.sv
// Saturating wait counter for memory handshakes; timeout is high in the last
// waiting cycle allowed before the access is declared failed.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMER_W     = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);
    localparam logic [TIMER_W-1:0] LAST  = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // This cycle's increment would reach MEM_TIMEOUT.
    assign timeout = (count_q >= LAST);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle RV32I control FSM with memory-wait timeout and trap sequencing.
// CONTROL_SEQUENCER_DEBUG_HALT_EN adds halt_req/halted and the HALTED state.
//
// state   | meaning
// RST     | post-reset, all strobes low
// FETCH   | read instruction at PC, wait for completion
// DECODE  | check instruction legality
// EXEC    | ALU / branch / CSR work, start memory access
// MEM     | data access at ALU address, wait for completion
// TRAP    | one-cycle trap pulse, PC loads the vector
// HALTED  | debug halt between instructions (optional)
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMER_W     = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
    input  logic halt_req,
    output logic halted,
`endif
    control_sequencer_if.master bus
);

    state_t     state_q, state_d;
    state_t     fetch_st;
    logic [3:0] cause_q, cause_d;
    logic       timer_en;
    logic       timeout;
    logic       is_load;
    logic       mem_done;
    logic       target_used;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_d != state_q),
        .enable (timer_en),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        timer_en        = 1'b0;
        is_load         = (bus.opcode == OPC_LOAD);
        mem_done        = 1'b0;
        target_used     = 1'b0;
        bus.check_inst   = 1'b0;
        bus.check_ialign = 1'b0;
        bus.check_mem    = 1'b0;
        bus.check_csr    = 1'b0;
        bus.write_pc     = 1'b0;
        bus.write_ir     = 1'b0;
        bus.write_rd     = 1'b0;
        bus.write_csr    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.addr_sel     = 1'b0;
        bus.rd_sel       = RD_ALU;
        bus.alu_insel1   = ALU1_RS1;
        bus.alu_insel2   = ALU2_RS2;
        bus.trap         = 1'b0;
`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
        halted          = 1'b0;
        // Every entry into FETCH is an instruction boundary, the only halt point.
        fetch_st        = halt_req ? ST_HALTED : ST_FETCH;
`else
        fetch_st        = ST_FETCH;
`endif

        case (state_q)
            ST_RST: state_d = fetch_st;

            ST_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_complete_read) begin
                    bus.write_ir = 1'b1;
                    state_d      = ST_DECODE;
                end else begin
                    timer_en = 1'b1;
                    if (timeout) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_IFETCH;
                    end
                end
            end

            ST_DECODE: begin
                bus.check_inst = 1'b1;
                if (bus.fault_inst) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (bus.opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                        bus.write_rd = 1'b1;
                        bus.rd_sel   = RD_ALU;
                        bus.write_pc = 1'b1;
                        bus.alu_insel1 = (bus.opcode == OPC_LUI)   ? ALU1_ZERO :
                                         (bus.opcode == OPC_AUIPC) ? ALU1_PC : ALU1_RS1;
                        bus.alu_insel2 = (bus.opcode == OPC_OP) ? ALU2_RS2 : ALU2_IMM;
                        state_d      = fetch_st;
                    end
                    OPC_JAL, OPC_JALR, OPC_BRANCH: begin
                        bus.alu_insel1   = (bus.opcode == OPC_JALR) ? ALU1_RS1 : ALU1_PC;
                        bus.alu_insel2   = ALU2_IMM;
                        target_used      = (bus.opcode != OPC_BRANCH) || bus.branch_taken;
                        bus.check_ialign = target_used;
                        if (target_used && bus.fault_ialign) begin
                            state_d = ST_TRAP;
                            cause_d = CAUSE_IALIGN;
                        end else begin
                            bus.write_pc = 1'b1;
                            if (bus.opcode != OPC_BRANCH) begin
                                bus.write_rd = 1'b1;
                                bus.rd_sel   = RD_PC4;
                            end
                            state_d = fetch_st;
                        end
                    end
                    OPC_LOAD, OPC_STORE: begin
                        bus.alu_insel1 = ALU1_RS1;
                        bus.alu_insel2 = ALU2_IMM;
                        bus.check_mem  = 1'b1;
                        if (bus.fault_mem) begin
                            state_d = ST_TRAP;
                            cause_d = is_load ? CAUSE_LOAD_ALIGN : CAUSE_STORE_ALIGN;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    OPC_SYSTEM: begin
                        bus.check_csr = 1'b1;
                        if (bus.fault_csr) begin
                            state_d = ST_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end else begin
                            bus.write_csr = 1'b1;
                            bus.write_rd  = 1'b1;
                            bus.rd_sel    = RD_CSR;
                            bus.write_pc  = 1'b1;
                            state_d       = fetch_st;
                        end
                    end
                    OPC_MISC_MEM: begin
                        bus.write_pc = 1'b1;
                        state_d      = fetch_st;
                    end
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                bus.addr_sel = 1'b1;
                // IR is stable through MEM, so opcode still tells load from store.
                if (is_load) begin
                    bus.mem_read = 1'b1;
                    mem_done     = bus.mem_complete_read;
                end else begin
                    bus.mem_write = 1'b1;
                    mem_done      = bus.mem_complete_write;
                end
                if (mem_done) begin
                    bus.write_pc = 1'b1;
                    if (is_load) begin
                        bus.write_rd = 1'b1;
                        bus.rd_sel   = RD_MEM;
                    end
                    state_d = fetch_st;
                end else begin
                    timer_en = 1'b1;
                    if (timeout) begin
                        state_d = ST_TRAP;
                        cause_d = is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
                    end
                end
            end

            ST_TRAP: begin
                bus.trap     = 1'b1;
                bus.write_pc = 1'b1;
                state_d      = fetch_st;
            end

`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
            ST_HALTED: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_d = ST_FETCH;
                end
            end
`endif

            default: state_d = ST_RST;
        endcase
    end

    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (default MEM_TIMEOUT=15).
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   nread;
    int   nir;
    int   ntrap;

    control_sequencer_if bus ();

`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
    logic halt_req;
    logic halted;
`endif

    control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
        .halt_req(halt_req),
        .halted  (halted),
`endif
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [21:0] strobes();
        return {bus.check_inst, bus.check_ialign, bus.check_mem, bus.check_csr,
                bus.write_pc, bus.write_ir, bus.write_rd, bus.write_csr,
                bus.mem_read, bus.mem_write, bus.addr_sel, bus.rd_sel,
                bus.alu_insel1, bus.alu_insel2, bus.trap};
    endfunction

    // From the first FETCH cycle: complete immediately, then stop in EXEC.
    task automatic quick_fetch_to_exec(input logic [6:0] opc);
        bus.opcode            = opc;
        bus.mem_complete_read = 1'b1;
        tick();
        bus.mem_complete_read = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.opcode             = OPC_OP;
        bus.f3                 = 3'd0;
        bus.mem_complete_read  = 1'b0;
        bus.mem_complete_write = 1'b0;
        bus.branch_taken       = 1'b0;
        bus.fault_inst         = 1'b0;
        bus.fault_ialign       = 1'b0;
        bus.fault_mem          = 1'b0;
        bus.fault_csr          = 1'b0;
`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
        halt_req               = 1'b0;
`endif
        tick();
        tick();
        chk("reset_strobes", 32'(strobes()), 0);
        chk("reset_cause", 32'(bus.trap_cause), 0);

        // OP fetch completing in the 4th cycle
        rst_n = 1'b1;
        tick();
        nread = 0;
        nir   = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_complete_read = (i == 3);
            #1;
            if (bus.mem_read) nread++;
            if (bus.write_ir) nir++;
            chk("fetch_addr_sel", 32'(bus.addr_sel), 0);
            if (i < 3) tick();
        end
        chk("fetch_read_cycles", nread, 4);
        chk("fetch_ir_pulses", nir, 1);
        tick();
        bus.mem_complete_read = 1'b0;
        #1;
        chk("decode_check_inst", 32'(bus.check_inst), 1);
        chk("decode_no_read", 32'(bus.mem_read), 0);
        tick();
        #1;
        chk("op_write_rd", 32'(bus.write_rd), 1);
        chk("op_rd_sel", 32'(bus.rd_sel), 0);
        chk("op_write_pc", 32'(bus.write_pc), 1);
        chk("op_alu2", 32'(bus.alu_insel2), 0);
        tick();
        #1;
        chk("op_back_fetch", 32'(bus.mem_read), 1);

        // LOAD, data returns in the 3rd MEM cycle
        quick_fetch_to_exec(OPC_LOAD);
        #1;
        chk("load_check_mem", 32'(bus.check_mem), 1);
        chk("load_alu2_imm", 32'(bus.alu_insel2), 1);
        tick();
        #1;
        chk("load_mem_addr_sel", 32'(bus.addr_sel), 1);
        chk("load_wait_no_rd", 32'(bus.write_rd), 0);
        tick();
        tick();
        bus.mem_complete_read = 1'b1;
        #1;
        chk("load_done_rd", 32'(bus.write_rd), 1);
        chk("load_done_rd_sel", 32'(bus.rd_sel), 1);
        chk("load_done_pc", 32'(bus.write_pc), 1);
        tick();
        bus.mem_complete_read = 1'b0;
        #1;
        chk("load_back_fetch", {bus.mem_read, bus.addr_sel}, 2'b10);

        // Fetch never completes: 15 waiting cycles, trap in the 16th
        nread = 0;
        ntrap = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (bus.mem_read) nread++;
            if (bus.trap) ntrap++;
            tick();
        end
        chk("ftimeout_read_cycles", nread, 15);
        chk("ftimeout_no_early_trap", ntrap, 0);
        #1;
        chk("ftimeout_trap", 32'(bus.trap), 1);
        chk("ftimeout_cause", 32'(bus.trap_cause), 1);
        chk("ftimeout_no_read", 32'(bus.mem_read), 0);
        tick();

        // Completion on the last allowed cycle still succeeds
        for (int i = 0; i < 14; i++) tick();
        bus.mem_complete_read = 1'b1;
        #1;
        chk("fetch_edge_ir", 32'(bus.write_ir), 1);
        tick();
        bus.mem_complete_read = 1'b0;
        #1;
        chk("fetch_edge_decode", 32'(bus.check_inst), 1);
        bus.opcode = OPC_BRANCH;
        tick();

        // Taken branch with misaligned target
        bus.branch_taken = 1'b1;
        bus.fault_ialign = 1'b1;
        #1;
        chk("br_check_ialign", 32'(bus.check_ialign), 1);
        chk("br_fault_no_pc", 32'(bus.write_pc), 0);
        chk("br_alu1_pc", 32'(bus.alu_insel1), 1);
        tick();
        bus.branch_taken = 1'b0;
        bus.fault_ialign = 1'b0;
        #1;
        chk("br_trap", 32'(bus.trap), 1);
        chk("br_cause", 32'(bus.trap_cause), 0);
        tick();

        // Branch not taken: no alignment check, PC+4
        quick_fetch_to_exec(OPC_BRANCH);
        bus.fault_ialign = 1'b1;
        #1;
        chk("brnt_no_check", 32'(bus.check_ialign), 0);
        chk("brnt_write_pc", 32'(bus.write_pc), 1);
        tick();
        bus.fault_ialign = 1'b0;

        // JAL links PC+4
        quick_fetch_to_exec(OPC_JAL);
        #1;
        chk("jal_rd", {bus.write_rd, bus.rd_sel, bus.write_pc}, 4'b1101);
        tick();

        // Illegal opcode
        quick_fetch_to_exec(7'h7F);
        tick();
        #1;
        chk("illegal_cause", {bus.trap, bus.trap_cause}, 5'h12);
        tick();

        // STORE data-phase timeout
        quick_fetch_to_exec(OPC_STORE);
        tick();
        nread = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (bus.mem_write && !bus.mem_read) nread++;
            tick();
        end
        chk("st_timeout_write_cycles", nread, 15);
        #1;
        chk("st_timeout_cause", {bus.trap, bus.trap_cause}, 5'h17);
        tick();

        // Reset during a STORE data phase
        quick_fetch_to_exec(OPC_STORE);
        tick();
        #1;
        chk("st_mem_write", 32'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", 32'(strobes()), 0);
        chk("async_rst_cause", 32'(bus.trap_cause), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_idle", 32'(bus.mem_read), 0);
        tick();
        #1;
        chk("rst_release_fetch", 32'(bus.mem_read), 1);

`ifdef CONTROL_SEQUENCER_DEBUG_HALT_EN
        // Halt requested while ADDI executes
        quick_fetch_to_exec(OPC_OP_IMM);
        halt_req = 1'b1;
        #1;
        chk("halt_addi_retires", 32'(bus.write_rd), 1);
        tick();
        #1;
        chk("halted_flag", 32'(halted), 1);
        chk("halted_no_read", 32'(bus.mem_read), 0);
        tick();
        halt_req = 1'b0;
        #1;
        chk("halted_hold", {halted, bus.mem_read}, 2'b10);
        tick();
        #1;
        chk("halt_resume", {halted, bus.mem_read}, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
